obc_da_mac: RTL and testbench



---
 rtl/obc_da_mac.sv | 159 +++++++++++++++
 tb/tb_obc_da_mac.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/obc_da_mac.sv
`default_nettype none
// ============================================================================
// obc_da_mac : bit-serial MSB-first OBC distributed-arithmetic inner product
//              with a loadable 2^(N_TAPS-1)-entry table.
// Optional   : OBC_DA_MAC_SAT_EN (saturating y_out plus sat_flag output).
// Revision   : 1.0
// ============================================================================
module obc_da_mac #(
  parameter  int N_TAPS = 4,
  parameter  int IN_W   = 8,
  parameter  int ROM_W  = 24,
  parameter  int OUT_W  = 32,
  localparam int ACC_W  = ROM_W + IN_W + 1,
  localparam int AW     = N_TAPS - 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rom_we,
  input  logic [AW-1:0]          rom_waddr,
  input  logic [ROM_W-1:0]       rom_wdata,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_TAPS*IN_W-1:0] x_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       y_out,
  output logic                   busy
`ifdef OBC_DA_MAC_SAT_EN
  ,output logic                  sat_flag
`endif
);

  localparam int BW = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_OFFS  = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;
  localparam logic [BW-1:0] c_MSB = BW'(IN_W - 1);

  logic [1:0]             r_state;
  logic [BW-1:0]          r_bit;
  logic [N_TAPS*IN_W-1:0] r_x;
  logic [ACC_W-1:0]       r_acc;
  logic [ROM_W-1:0]       r_rom [2**AW];
  logic [OUT_W-1:0]       r_y;

  logic [IN_W-1:0]        w_tap [N_TAPS];
  logic [N_TAPS-1:0]      w_bit;
  logic [AW-1:0]          w_addr;
  logic [ROM_W-1:0]       w_entry;
  logic [ROM_W-1:0]       w_entry0;
  logic [ACC_W-1:0]       w_tab;
  logic [ACC_W-1:0]       w_t;
  logic [ACC_W-1:0]       w_off;
  logic [ACC_W-1:0]       w_shift;
  logic [ACC_W-1:0]       w_sum;
  logic [OUT_W-1:0]       w_y;

  generate
    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
      assign w_tap[k] = r_x[k*IN_W +: IN_W];
      assign w_bit[k] = w_tap[k][r_bit];
    end
    // Tap 0 sign-folds the address so only half the combinations are stored.
    for (genvar k = 1; k < N_TAPS; k++) begin : g_addr
      assign w_addr[k-1] = w_bit[k] ^ w_bit[0];
    end
  endgenerate

  assign w_entry  = r_rom[w_addr];
  assign w_entry0 = r_rom[0];
  assign w_tab    = {{(ACC_W-ROM_W){w_entry[ROM_W-1]}}, w_entry};
  assign w_off    = {{(ACC_W-ROM_W){w_entry0[ROM_W-1]}}, w_entry0};
  assign w_t      = w_bit[0] ? (~w_tab + 1'b1) : w_tab;
  assign w_shift  = (r_bit == c_MSB) ? (~w_t + 1'b1)
                                     : ({r_acc[ACC_W-2:0], 1'b0} + w_t);
  assign w_sum    = r_acc + w_off;

`ifdef OBC_DA_MAC_SAT_EN
  logic w_ovf;
  logic r_sat;
`endif

  generate
    if (OUT_W < ACC_W) begin : g_narrow
`ifdef OBC_DA_MAC_SAT_EN
      logic [ACC_W-OUT_W:0] w_hi;
      assign w_hi  = w_sum[ACC_W-1:OUT_W-1];
      assign w_ovf = !((&w_hi) || !(|w_hi));
      assign w_y   = w_ovf ? {w_sum[ACC_W-1], {(OUT_W-1){~w_sum[ACC_W-1]}}}
                           : w_sum[OUT_W-1:0];
`else
      assign w_y   = w_sum[OUT_W-1:0];
`endif
    end else if (OUT_W == ACC_W) begin : g_equal
      assign w_y   = w_sum;
`ifdef OBC_DA_MAC_SAT_EN
      assign w_ovf = 1'b0;
`endif
    end else begin : g_wide
      assign w_y   = {{(OUT_W-ACC_W){w_sum[ACC_W-1]}}, w_sum};
`ifdef OBC_DA_MAC_SAT_EN
      assign w_ovf = 1'b0;
`endif
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_bit   <= '0;
      r_x     <= '0;
      r_acc   <= '0;
      r_y     <= '0;
      for (int i = 0; i < 2**AW; i++) r_rom[i] <= '0;
    end else begin
      if (rom_we && (r_state == c_IDLE)) r_rom[rom_waddr] <= rom_wdata;
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_x     <= x_in;
            r_acc   <= '0;
            r_bit   <= c_MSB;
            r_state <= c_SHIFT;
          end
        end
        c_SHIFT: begin
          r_acc <= w_shift;
          if (r_bit == '0) r_state <= c_OFFS;
          else             r_bit   <= r_bit - BW'(1);
        end
        c_OFFS: begin
          r_acc   <= w_sum;
          r_y     <= w_y;
          r_state <= c_DONE;
        end
        c_DONE: begin
          if (out_ready) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

`ifdef OBC_DA_MAC_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_sat <= 1'b0;
    else if (r_state == c_OFFS)  r_sat <= w_ovf;
  end
  assign sat_flag = r_sat;
`endif

  assign in_ready  = (r_state == c_IDLE);
  assign out_valid = (r_state == c_DONE);
  assign busy      = (r_state == c_SHIFT) || (r_state == c_OFFS);
  assign y_out     = r_y;

endmodule
`default_nettype wire

// File: tb/tb_obc_da_mac.sv
`default_nettype none
// tb_obc_da_mac : scoreboard bench running a 32-bit and a 12-bit result
// instance side by side from the same stimulus.
`timescale 1ns/1ps
module tb_obc_da_mac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_we = 1'b0;
  logic [2:0]  rom_waddr = '0;
  logic [23:0] rom_wdata = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x_in = '0;

  logic        in_ready_a, out_valid_a, busy_a;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [31:0] y_a;
  logic [11:0] y_b;
`ifdef OBC_DA_MAC_SAT_EN
  logic        sat_a, sat_b;
`endif

  always #5 clk = ~clk;

  obc_da_mac #(.N_TAPS(4), .IN_W(8), .ROM_W(24), .OUT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .in_valid(in_valid), .in_ready(in_ready_a),
    .x_in(x_in), .out_valid(out_valid_a), .out_ready(out_ready),
    .y_out(y_a), .busy(busy_a)
`ifdef OBC_DA_MAC_SAT_EN
    , .sat_flag(sat_a)
`endif
  );

  obc_da_mac #(.N_TAPS(4), .IN_W(8), .ROM_W(24), .OUT_W(12)) dut_b (
    .clk(clk), .rst_n(rst_n), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .in_valid(in_valid), .in_ready(in_ready_b),
    .x_in(x_in), .out_valid(out_valid_b), .out_ready(out_ready),
    .y_out(y_b), .busy(busy_b)
`ifdef OBC_DA_MAC_SAT_EN
    , .sat_flag(sat_b)
`endif
  );

  typedef struct {
    longint ya;
    longint yb;
    bit     sa;
    bit     sb;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     checks = 0;
  int     errors = 0;
  int     coef [4];

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  function automatic longint dot(input logic [31:0] xv);
    longint s = 0;
    for (int k = 0; k < 4; k++) begin
      logic signed [7:0] xk;
      xk = xv[k*8 +: 8];
      s += longint'(coef[k]) * longint'(xk);
    end
    return s;
  endfunction

  // Reference output formatting: wrap by default, clamp when saturation is built in.
  function automatic longint fitw(input longint v, input int w, output bit s);
    longint mx, mn, m;
    mx = (longint'(1) <<< (w-1)) - 1;
    mn = -mx - 1;
    s  = 1'b0;
`ifdef OBC_DA_MAC_SAT_EN
    if (v > mx)      begin s = 1'b1; return mx; end
    else if (v < mn) begin s = 1'b1; return mn; end
    return v;
`else
    m = v & ((longint'(1) <<< w) - 1);
    if (m > mx) m -= (longint'(1) <<< w);
    return m;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid_a && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("y32", longint'($signed(y_a)), mon_e.ya);
        check("y12", longint'($signed(y_b)), mon_e.yb);
        check("valid12_aligned", out_valid_b, 1);
`ifdef OBC_DA_MAC_SAT_EN
        check("sat32", sat_a, mon_e.sa);
        check("sat12", sat_b, mon_e.sb);
`endif
      end
    end
  end

  task automatic load_table(input int c0, input int c1, input int c2, input int c3);
    int t;
    coef[0] = c0; coef[1] = c1; coef[2] = c2; coef[3] = c3;
    for (int a = 0; a < 8; a++) begin
      t = -coef[0];
      for (int k = 1; k < 4; k++) t += ((a >> (k-1)) & 1) ? coef[k] : -coef[k];
      t = t / 2;
      rom_we    = 1'b1;
      rom_waddr = a[2:0];
      rom_wdata = t[23:0];
      @(posedge clk); #1;
    end
    rom_we = 1'b0;
  endtask

  task automatic op(input logic [31:0] xv, input int hold, input bit keep_valid, input bit poke_rom);
    exp_t   e;
    bit     s;
    int     n;
    longint d;
    x_in     = xv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready_a && n < 50) begin @(posedge clk); #1; n++; end
    if (!in_ready_a) check("accept_timeout", in_ready_a, 1);
    d    = dot(xv);
    e.ya = fitw(d, 32, s); e.sa = s;
    e.yb = fitw(d, 12, s); e.sb = s;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    x_in = ~xv;
    n = 0;
    while (!out_valid_a && n < 40) begin
      if (n == 1) check("busy_in_shift", busy_a, 1);
      if (poke_rom && n == 2) begin
        rom_we = 1'b1; rom_waddr = 3'd0; rom_wdata = 24'h123456;
      end else begin
        rom_we = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    rom_we = 1'b0;
    check("latency", n, 9);
    check("busy_done", busy_a, 0);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", out_valid_a, 1);
      check("hold_in_ready", in_ready_a, 0);
      check("hold_y", longint'($signed(y_a)), e.ya);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_dropped", out_valid_a, 0);
    check("in_ready_back", in_ready_a, 1);
  endtask

  initial begin
    int stray;
    coef = '{0, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_a, 1);
    check("rst_out_valid", out_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_y", longint'(y_a), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    load_table(2, 4, 6, 8);
    op(pack(1, 1, 1, 1), 0, 0, 0);
    op(pack(127, 127, 127, 127), 0, 0, 0);
    op(pack(0, 0, 0, 0), 0, 0, 0);
    op(pack(-1, 2, -3, 4), 0, 0, 0);
    op(pack(-128, -128, -128, -128), 0, 0, 0);

    // Backpressure with in_valid held high; the follow-up is accepted on the next edge.
    op(pack(3, -5, 7, -9), 5, 1, 0);
    op(pack(100, -100, 50, -50), 0, 0, 0);

    // Table write during SHIFT must be dropped.
    op(pack(1, 1, 1, 1), 0, 0, 1);

    load_table(10, -4, 6, 2);
    op(pack(5, -7, 9, 11), 0, 0, 0);

    // Abort mid-operation at bit index 3.
    load_table(2, 4, 6, 8);
    x_in = pack(1, 1, 1, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_abort_busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid_a, 0);
    check("abort_in_ready", in_ready_a, 1);
    check("abort_busy", busy_a, 0);
    check("abort_y", longint'(y_a), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    coef = '{0, 0, 0, 0};
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid_a) stray++;
    end
    check("no_partial_result", stray, 0);
    op(pack(1, 1, 1, 1), 0, 0, 0);
    load_table(2, 4, 6, 8);
    op(pack(1, 1, 1, 1), 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
